matrix_arb_lock: RTL and testbench
==================================

Name: matrix_arb_lock

Overview:
- Parametrised matrix (least-recently-granted) arbiter for switch output ports, with wormhole packet locking and a valid/ready handshake.
- The priority matrix updates only on an accepted transfer.
- Once a multi-flit packet wins, the grant is held on its owner until the tail flit is accepted.
- Instanced once per switch output port; replaces the unlocked arbiter where packets span multiple flits.

Parameters:
- IN_N, 5, number of requesters; must be >= 2 (elaboration error otherwise).
- IDX_W, $clog2(IN_N), width of the encoded grant; derived, not overridden.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  IN_N  per-requester request (flit valid)
- last_i  in  IN_N  per-requester tail-flit flag; qualified by req_i
- ready_i  in  1  downstream accepts the granted flit this cycle
- grant_oh_o  out  IN_N  one-hot grant; all zeros when no grant
- grant_o  out  IDX_W  encoded grant index; 0 when grant_vld_o=0
- grant_vld_o  out  1  a grant is asserted this cycle
- locked_o  out  1  arbiter is locked to an owner (LOCKED state)

Behaviour:
- Storage:
  - Only the strict upper triangle is stored: p[i][j] for i<j, IN_N*(IN_N-1)/2 flops.
  - p[j][i] = ~p[i][j]. p[i][j]=1 means i has priority over j.
- Reset (async):
  - All stored p bits = 1, so lower index has higher priority.
  - state=IDLE, owner=0, locked_o=0.
  - Grant outputs are combinational from req_i and the reset matrix; with req_i=0 all grant outputs are 0.
- Transfer definition: xfer = grant_vld_o & ready_i.
- IDLE grant (combinational):
  - Requester k wins iff req_i[k] and no other requester j has req_i[j] & prio(j over k).
  - Exactly one winner whenever req_i != 0.
- IDLE grant stability: the grant is not sticky before xfer. If ready_i=0, the grant may change next cycle when req_i changes. The matrix and state are unchanged.
- IDLE, xfer with last_i[k]=1 (single-flit packet):
  - Matrix update: k drops to lowest (p[k][j]=0 for j>k, p[j][k]=1 for j<k).
  - Remain IDLE.
- IDLE, xfer with last_i[k]=0:
  - Same matrix update.
  - owner<=k, state<=LOCKED, locked_o=1 from the next cycle.
- LOCKED grant:
  - grant_oh_o/grant_o = owner regardless of other requests; grant_vld_o = req_i[owner].
  - If the owner drops req_i, grant_vld_o=0 (bubble) and the lock is held.
- LOCKED, xfer with last_i[owner]=1:
  - state<=IDLE; locked_o=0 next cycle.
  - No matrix update (already done at head).
  - The new arbitration takes effect the cycle after the tail.
- LOCKED, xfer with last_i[owner]=0: stay LOCKED.
- Zero-cycle arbitration: in IDLE, grant is valid in the same cycle as req_i. Matrix/state changes are visible one cycle after xfer.
- last_i of non-granted requesters is ignored.
- Reset mid-packet: immediate return to IDLE with the reset matrix. The packet in flight is the upstream's responsibility.
- Invariants (bench assertions): $onehot0(grant_oh_o); grant_vld_o == |grant_oh_o; grant_oh_o[grant_o] when valid; no grant to k without req_i[k].

Decomposition:
- Shared switch package: IN_N default (port count 5), port index constants.
- Sub-module matrix_prio_tri: triangular matrix storage plus the combinational winner logic.
  - Inputs: req vector, update enable, update index.
  - Output: one-hot winner.
  - Reusable by the allocator.
- Top level holds the IDLE/LOCKED FSM, the owner register, output muxing and one-hot-to-index encoding.

Test Plan:
- Reset, IN_N=5, req_i=5'b10110, ready_i=1, last_i=all 1 held 3 cycles -> grant_o 1, 2, 4; then 1 again in cycle 4. locked_o=0 throughout.
- ready_i=0, req_i=5'b00101 for 3 cycles -> grant_o=0 steady with no matrix change. Then ready_i=1 for 1 cycle -> grant_o=2 on the following cycle.
- Lock: req_i=5'b00011, last_i=0, ready_i=1 -> grant 0, locked_o=1 next cycle. Raise req_i=5'b11111 for 3 cycles -> grant_o stays 0. last_i[0]=1 -> release; next cycle grant_o=1, locked_o=0.
- Owner bubble: locked to 3, req_i[3]=0 for 2 cycles while req_i[1]=1 -> grant_vld_o=0, grant_oh_o=0, locked_o=1. req_i[3] back -> grant_o=3.
- Async reset asserted while locked to 2 -> locked_o=0 immediately. After release, req_i=5'b11100 -> grant_o=2 (reset priority).
- Random 10k cycles with IN_N=3 and IN_N=8 plus invariant assertions -> no starvation: every continuously requesting port is granted within IN_N packets.

Source files
------------

// File: rtl/matrix_arb_lock_pkg.sv
// matrix_arb_lock_pkg: shared switch constants (default port count, port indices, arbiter FSM states)
package matrix_arb_lock_pkg;
  localparam int IN_N_DEF   = 5;
  localparam int PORT_LOCAL = 0;
  localparam int PORT_N     = 1;
  localparam int PORT_E     = 2;
  localparam int PORT_S     = 3;
  localparam int PORT_W     = 4;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
endpackage

// File: rtl/matrix_arb_lock_prio_tri.sv
// matrix_prio_tri: triangular LRG priority matrix; in clk_i/rst_ni/req_i/upd_i/upd_idx_i, out win_oh_o (one-hot winner)
module matrix_prio_tri
  import matrix_arb_lock_pkg::*;
#(
  parameter int N = IN_N_DEF,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_i,
  input  logic             upd_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  output logic [N-1:0]     win_oh_o
);
  logic [N-1:0][N-1:0] beat;
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (i < j) begin : g_up
        logic p_q;
        always_ff @(posedge clk_i or negedge rst_ni)
          if (!rst_ni) p_q <= 1'b1;
          else if (upd_i && (upd_idx_i == IDX_W'(i) || upd_idx_i == IDX_W'(j))) p_q <= upd_idx_i == IDX_W'(j);
        assign beat[j][i] = p_q;
        assign beat[i][j] = ~p_q;
      end else if (i == j) begin : g_diag
        assign beat[i][i] = 1'b0;
      end
    end
    assign win_oh_o[i] = req_i[i] & ~|(req_i & beat[i]);
  end
endmodule

// File: rtl/matrix_arb_lock.sv
// matrix_arb_lock: LRG arbiter with wormhole lock; in clk_i/rst_ni/req_i/last_i/ready_i, out grant_oh_o/grant_o/grant_vld_o/locked_o
module matrix_arb_lock
  import matrix_arb_lock_pkg::*;
#(
  parameter int IN_N = IN_N_DEF,
  localparam int IDX_W = $clog2(IN_N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IN_N-1:0]  req_i,
  input  logic [IN_N-1:0]  last_i,
  input  logic             ready_i,
  output logic [IN_N-1:0]  grant_oh_o,
  output logic [IDX_W-1:0] grant_o,
  output logic             grant_vld_o,
  output logic             locked_o
);
  if (IN_N < 2) begin : g_chk
    $error("matrix_arb_lock: IN_N must be >= 2");
  end
  logic [0:0]       state_q;
  logic [IDX_W-1:0] owner_q;
  logic [IN_N-1:0]  win_oh;
  logic             xfer, tail;
  matrix_prio_tri #(.N(IN_N)) u_prio (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .upd_i     (xfer & ~locked_o),
    .upd_idx_i (grant_o),
    .win_oh_o  (win_oh)
  );
  assign locked_o    = state_q == ST_LOCKED;
  assign grant_oh_o  = locked_o ? (IN_N'(1) << owner_q) & req_i : win_oh;
  assign grant_vld_o = |grant_oh_o;
  assign xfer        = grant_vld_o & ready_i;
  assign tail        = |(grant_oh_o & last_i);
  always_comb begin
    grant_o = '0;
    for (int k = 0; k < IN_N; k++) grant_o = grant_oh_o[k] ? IDX_W'(k) : grant_o;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
    end else if (xfer) begin
      state_q <= tail ? ST_IDLE : ST_LOCKED;
      owner_q <= grant_o;
    end
endmodule

// File: tb/tb_matrix_arb_lock.sv
// tb_matrix_arb_lock: directed checks on IN_N=5 plus random invariant/starvation runs on IN_N=3 and IN_N=8
module tb_matrix_arb_lock;
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;
  logic [4:0] req5, last5, oh5;
  logic       rdy5, v5, l5;
  logic [2:0] g5;
  logic [2:0] req3, last3, oh3;
  logic       rdy3, v3, l3;
  logic [1:0] g3;
  logic [7:0] req8, last8, oh8;
  logic       rdy8, v8, l8;
  logic [2:0] g8;
  logic [7:0] p3, p8, lt;
  logic [7:0][7:0] w3, w8;
  logic rt;
  int total = 0;
  int bad = 0;
  matrix_arb_lock #(.IN_N(5)) dut (.clk_i(clk), .rst_ni(rst_ni), .req_i(req5), .last_i(last5), .ready_i(rdy5),
    .grant_oh_o(oh5), .grant_o(g5), .grant_vld_o(v5), .locked_o(l5));
  matrix_arb_lock #(.IN_N(3)) d3 (.clk_i(clk), .rst_ni(rst_ni), .req_i(req3), .last_i(last3), .ready_i(rdy3),
    .grant_oh_o(oh3), .grant_o(g3), .grant_vld_o(v3), .locked_o(l3));
  matrix_arb_lock #(.IN_N(8)) d8 (.clk_i(clk), .rst_ni(rst_ni), .req_i(req8), .last_i(last8), .ready_i(rdy8),
    .grant_oh_o(oh8), .grant_o(g8), .grant_vld_o(v8), .locked_o(l8));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic inv(input string tag, input logic [7:0] oh, input logic [7:0] req, input logic [2:0] g, input logic v);
    chk({tag, ".onehot"}, 32'($onehot0(oh)), 1);
    chk({tag, ".vld"}, v, |oh);
    chk({tag, ".idx"}, oh, v ? 8'(1) << g : 8'h0);
    chk({tag, ".noreq"}, oh & ~req, 0);
    if (!v) chk({tag, ".idx0"}, g, 0);
  endtask
  task automatic exp5(input string tag, input int g, input logic v, input logic l);
    chk({tag, ".g"}, g5, v ? g : 0);
    chk({tag, ".v"}, v5, v);
    chk({tag, ".l"}, l5, l);
    chk({tag, ".oh"}, oh5, v ? 32'(1) << g : 0);
    inv({tag, ".inv"}, {3'b0, oh5}, {3'b0, req5}, g5, v5);
  endtask
  task automatic set5(input logic [4:0] r, input logic [4:0] la, input logic rd);
    req5 = r;
    last5 = la;
    rdy5 = rd;
    #1;
  endtask
  task automatic nxt;
    @(posedge clk);
    #2;
  endtask
  task automatic stim(input int n, inout logic [7:0] p, inout logic [7:0][7:0] w, output logic [7:0] la, output logic rd);
    for (int j = 0; j < n; j++)
      if (!p[j] && $urandom_range(3) == 0) begin
        p[j] = 1'b1;
        w[j] = 8'd0;
      end
    la = 8'($urandom);
    rd = $urandom_range(3) != 0;
  endtask
  task automatic upd(input string tag, input int n, input logic [7:0] la, input logic [2:0] g, input logic v,
                     input logic rd, input logic lk, inout logic [7:0] p, inout logic [7:0][7:0] w);
    if (v && rd) begin
      if (!lk) begin
        for (int j = 0; j < n; j++) if (j != int'(g) && p[j]) w[j] = w[j] + 8'd1;
        w[g] = 8'd0;
      end
      if (la[g]) p[g] = 1'b0;
    end
    for (int j = 0; j < n; j++) chk({tag, ".starve"}, 32'(w[j] > 8'(n - 1)), 0);
  endtask
  initial begin
    rst_ni = 1'b0;
    req3 = '0; last3 = '0; rdy3 = 1'b0;
    req8 = '0; last8 = '0; rdy8 = 1'b0;
    set5(5'b00000, 5'b00000, 1'b0);
    #10;
    exp5("reset", 0, 1'b0, 1'b0);
    rst_ni = 1'b1;
    set5(5'b10110, 5'b11111, 1'b1);
    exp5("rr1", 1, 1'b1, 1'b0);
    nxt; exp5("rr2", 2, 1'b1, 1'b0);
    nxt; exp5("rr3", 4, 1'b1, 1'b0);
    nxt; exp5("rr4", 1, 1'b1, 1'b0);
    nxt; set5(5'b00101, 5'b11111, 1'b0);
    exp5("hold1", 0, 1'b1, 1'b0);
    nxt; exp5("hold2", 0, 1'b1, 1'b0);
    nxt; exp5("hold3", 0, 1'b1, 1'b0);
    set5(5'b00101, 5'b11111, 1'b1);
    exp5("hold_go", 0, 1'b1, 1'b0);
    nxt; set5(5'b00101, 5'b11111, 1'b0);
    exp5("hold_next", 2, 1'b1, 1'b0);
    rst_ni = 1'b0;
    #1 rst_ni = 1'b1;
    set5(5'b00011, 5'b00000, 1'b1);
    exp5("lock_head", 0, 1'b1, 1'b0);
    nxt; set5(5'b11111, 5'b00000, 1'b1);
    exp5("lock1", 0, 1'b1, 1'b1);
    nxt; exp5("lock2", 0, 1'b1, 1'b1);
    nxt; exp5("lock3", 0, 1'b1, 1'b1);
    set5(5'b11111, 5'b00001, 1'b1);
    exp5("lock_tail", 0, 1'b1, 1'b1);
    nxt; set5(5'b11111, 5'b00000, 1'b0);
    exp5("released", 1, 1'b1, 1'b0);
    set5(5'b01000, 5'b00000, 1'b1);
    exp5("own3_head", 3, 1'b1, 1'b0);
    nxt; set5(5'b00010, 5'b00000, 1'b1);
    exp5("bubble1", 0, 1'b0, 1'b1);
    nxt; exp5("bubble2", 0, 1'b0, 1'b1);
    nxt; set5(5'b01010, 5'b00000, 1'b1);
    exp5("own3_back", 3, 1'b1, 1'b1);
    nxt; set5(5'b01010, 5'b01000, 1'b1);
    exp5("own3_tail", 3, 1'b1, 1'b1);
    nxt; set5(5'b00100, 5'b00000, 1'b1);
    exp5("own2_head", 2, 1'b1, 1'b0);
    nxt; exp5("own2_lock", 2, 1'b1, 1'b1);
    rst_ni = 1'b0;
    #1;
    exp5("async_rst", 2, 1'b1, 1'b0);
    set5(5'b11100, 5'b00000, 1'b0);
    rst_ni = 1'b1;
    #1;
    exp5("post_rst", 2, 1'b1, 1'b0);
    nxt; exp5("post_rst2", 2, 1'b1, 1'b0);
    p3 = '0; p8 = '0; w3 = '0; w8 = '0;
    for (int c = 0; c < 10000; c++) begin
      stim(3, p3, w3, lt, rt);
      req3 = p3[2:0]; last3 = lt[2:0]; rdy3 = rt;
      stim(8, p8, w8, lt, rt);
      req8 = p8; last8 = lt; rdy8 = rt;
      #1;
      inv("r3", {5'b0, oh3}, {5'b0, req3}, {1'b0, g3}, v3);
      inv("r8", oh8, req8, g8, v8);
      upd("r3", 3, {5'b0, last3}, {1'b0, g3}, v3, rdy3, l3, p3, w3);
      upd("r8", 8, last8, g8, v8, rdy8, l8, p8, w8);
      nxt;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
